// File: rtl/mayak_clk_pkg.sv
// mayak_clk_pkg: shared FSM state type, clock default, prescale and counter-width helpers
package mayak_clk_pkg;
  typedef enum logic [1:0] {SETTLE, IDLE, RUN} state_t;
  localparam int unsigned CLK_FREQ_HZ_DEFAULT = 50_000_000;
  function automatic int unsigned prescale(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/us_prescaler.sv
// us_prescaler: modulo-PRESCALE counter (clk, rst in; tick out, one-cycle pulse registered on each wrap)
module us_prescaler
  import mayak_clk_pkg::*;
#(
  parameter int unsigned PRESCALE = 50
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned W = cnt_w(PRESCALE);
  logic [W-1:0] cnt;
  logic wrap;
  assign wrap = cnt == W'(PRESCALE - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= wrap ? '0 : cnt + 1'b1;
      tick <= wrap;
    end
  end
endmodule

// File: rtl/osc_sample_timer.sv
// osc_sample_timer: settle hold-off, 1 us tick and periodic sample req/ack with overrun count (CLK/RESET/ENABLE/PERIOD_US/SAMPLE_ACK/CLR_OVR in; READY/US_TICK/SAMPLE_REQ/OVERRUN/OVERRUN_CNT out)
module osc_sample_timer
  import mayak_clk_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int unsigned TICK_HZ     = 1_000_000,
  parameter int unsigned SETTLE_US   = 100,
  parameter int unsigned PERIOD_W    = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ENABLE,
  input  logic [PERIOD_W-1:0] PERIOD_US,
  input  logic                SAMPLE_ACK,
  input  logic                CLR_OVR,
  output logic                READY,
  output logic                US_TICK,
  output logic                SAMPLE_REQ,
  output logic                OVERRUN,
  output logic [7:0]          OVERRUN_CNT
);
  localparam int unsigned PRESCALE = prescale(CLK_FREQ_HZ, TICK_HZ);
  if (CLK_FREQ_HZ % TICK_HZ != 0 || PRESCALE < 2) begin : g_bad_prescale
    $error("osc_sample_timer: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
  end
  if (SETTLE_US < 1 || SETTLE_US > 65535) begin : g_bad_settle
    $error("osc_sample_timer: SETTLE_US must be in 1..65535");
  end
  state_t state, state_n;
  logic [15:0] settle_cnt, settle_n;
  logic [PERIOD_W-1:0] pcnt, pcnt_n, period_eff;
  logic tick, ev, ovf;
  us_prescaler #(.PRESCALE(PRESCALE)) u_pre (.clk(CLK), .rst(RESET), .tick(tick));
  assign period_eff = (PERIOD_US == '0) ? PERIOD_W'(1) : PERIOD_US;
  assign ovf = ev & SAMPLE_REQ & ~SAMPLE_ACK;
  always_comb begin
    state_n  = state;
    settle_n = settle_cnt;
    pcnt_n   = pcnt;
    ev       = 1'b0;
    case (state)
      SETTLE: if (tick) begin
        settle_n = settle_cnt + 16'd1;
        state_n  = (settle_cnt == 16'(SETTLE_US - 1)) ? IDLE : SETTLE;
      end
      IDLE: begin
        state_n = ENABLE ? RUN : IDLE;
        pcnt_n  = ENABLE ? period_eff : '0;
      end
      RUN: if (!ENABLE) begin
        state_n = IDLE;
        pcnt_n  = '0;
      end else if (US_TICK) begin
        ev     = pcnt == PERIOD_W'(1);
        pcnt_n = ev ? period_eff : pcnt - 1'b1;
      end
      default: state_n = SETTLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= SETTLE;
      settle_cnt  <= '0;
      pcnt        <= '0;
      READY       <= 1'b0;
      US_TICK     <= 1'b0;
      SAMPLE_REQ  <= 1'b0;
      OVERRUN     <= 1'b0;
      OVERRUN_CNT <= '0;
    end else begin
      state       <= state_n;
      settle_cnt  <= settle_n;
      pcnt        <= pcnt_n;
      READY       <= state_n != SETTLE;
      US_TICK     <= tick & READY;
      SAMPLE_REQ  <= ev | (SAMPLE_REQ & ~SAMPLE_ACK);
      OVERRUN     <= ovf | (OVERRUN & ~CLR_OVR);
      OVERRUN_CNT <= CLR_OVR ? {7'd0, ovf} : OVERRUN_CNT + {7'd0, ovf && OVERRUN_CNT != 8'hFF};
    end
  end
endmodule

// File: doc/osc_sample_timer.md
# osc_sample_timer

Fabric-side timing stage downstream of the on-chip 25/50 MHz RC oscillator: it consumes the 50 MHz oscillator clock (routed onto the global clock network through CLKINT) and produces the DAC/ADC sample cadence for the Mayak design. It holds off for an oscillator settle interval, then derives a 1 µs tick and issues periodic sample requests. Requests use a req/ack handshake with the converter control logic, and missed samples are counted as overruns.

## Interface

- CLK_FREQ_HZ, 50_000_000, frequency of CLK.
- TICK_HZ, 1_000_000, tick rate.
  - PRESCALE = CLK_FREQ_HZ/TICK_HZ must be an integer ≥ 2.
  - Elaboration fails otherwise.
- SETTLE_US, 100, oscillator settle time in ticks; range 1..65535.
- PERIOD_W, 16, width of PERIOD_US.

Ports:

- CLK in 1: 50 MHz oscillator fabric clock (RCOSC_25_50MHZ_O2F). This is the block's only clock.
- RESET in 1: synchronous, active-high.
- ENABLE in 1: run the sample cadence.
- PERIOD_US in PERIOD_W: sample period in µs. A value of 0 is treated as 1.
- SAMPLE_ACK in 1: consumer has accepted the pending request.
- CLR_OVR in 1: clears OVERRUN and OVERRUN_CNT.
- READY out 1: settle interval complete.
- US_TICK out 1: one-cycle pulse every PRESCALE cycles; gated to 0 while READY=0.
- SAMPLE_REQ out 1: level request, held until acknowledged.
- OVERRUN out 1: sticky flag for a missed sample.
- OVERRUN_CNT out 8: saturating count of missed samples.

## Operation

Reset values: READY=0, US_TICK=0, SAMPLE_REQ=0, OVERRUN=0, OVERRUN_CNT=0, prescaler=0, state=SETTLE.

Prescaler:
- Free-running counter 0..PRESCALE-1 that wraps.
- The internal tick is true on the wrap. It runs in all states.

State machine:
- SETTLE:
  - Counts internal ticks.
  - After the SETTLE_US-th tick, moves to IDLE and sets READY=1.
  - READY stays 1 until RESET.
- IDLE:
  - Period counter is held at 0.
  - ENABLE=1 moves to RUN and loads the period counter with max(PERIOD_US,1).
- RUN:
  - Each US_TICK decrements the period counter.
  - When the decrement reaches 0, a sample event fires and the counter reloads from the current max(PERIOD_US,1).
  - PERIOD_US changes take effect at the next reload.
  - ENABLE=0 moves to IDLE on the next cycle; no further events fire.

Sample event:
- If SAMPLE_REQ=0, or SAMPLE_ACK=1 in the same cycle: SAMPLE_REQ is 1 in the next cycle.
- Otherwise the event is an overrun: OVERRUN←1 and OVERRUN_CNT increments, saturating at 255. SAMPLE_REQ stays 1.

Handshake:
- SAMPLE_REQ falls in the cycle after SAMPLE_ACK=1 is sampled with SAMPLE_REQ=1.
- Exception: a sample event in that same cycle keeps SAMPLE_REQ=1 with no gap, and no overrun is recorded.
- SAMPLE_ACK while SAMPLE_REQ=0 is ignored.
- Leaving RUN never drops a pending SAMPLE_REQ; it completes normally via ACK.

Overrun clear:
- CLR_OVR=1 clears OVERRUN and OVERRUN_CNT on the next cycle.
- If an overrun occurs in the same cycle as CLR_OVR, the result is OVERRUN=1 and OVERRUN_CNT=1.

RESET mid-operation:
- All state returns to reset values, including a pending SAMPLE_REQ.
- The settle interval restarts.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- First internal tick: PRESCALE cycles after RESET deasserts.
- READY rises SETTLE_US·PRESCALE+1 cycles after RESET deasserts. For the defaults this is cycle 5001.
- US_TICK: period exactly PRESCALE cycles, one cycle wide.
- First SAMPLE_REQ after entering RUN: on the PERIOD_US-th US_TICK following the state change, plus 1 cycle.
- Sustained request period: PERIOD_US·PRESCALE cycles.
- Minimum handshake round trip: REQ rises → ACK same cycle → REQ falls the next cycle.

## Structure

- Shared package mayak_clk_pkg holds:
  - the state enum (SETTLE, IDLE, RUN);
  - the CLK_FREQ_HZ default;
  - the PRESCALE computation and its clog2 width function.
- Sub-module us_prescaler: the modulo-PRESCALE counter producing the internal tick.
- The top level holds the FSM, period counter, handshake, and overrun logic.

## Test plan

- Reset release, defaults:
  - US_TICK stays 0 and READY=0 through cycle 5000.
  - READY=1 at cycle 5001.
  - US_TICK pulses every 50 cycles from then on.
- PERIOD_US=3, ENABLE=1 in IDLE, ACK returned 2 cycles after each REQ:
  - SAMPLE_REQ rises every 150 cycles.
  - OVERRUN_CNT stays 0.
- PERIOD_US=1, SAMPLE_ACK never asserted for 300 ticks:
  - SAMPLE_REQ remains 1.
  - OVERRUN=1.
  - OVERRUN_CNT saturates at 255.
- ACK in the same cycle as a sample event: SAMPLE_REQ stays 1 continuously and no overrun is recorded. Then CLR_OVR coinciding with an overrun: OVERRUN_CNT=1.
- PERIOD_US=0, ENABLE=1: SAMPLE_REQ rises every 50 cycles, the same as PERIOD_US=1.
- Mode and reset changes:
  - ENABLE dropped with REQ pending: REQ holds until ACK, and no new requests fire.
  - RESET asserted mid-RUN: all outputs return to 0 and READY reasserts after 5000 more cycles.
